// File: rtl/cipher_stream_sequencer.sv
// Byte-serial Vigenere A-Z cipher sequencer: key table, rotating key index, one message per start.
// Optional macro LOWERCASE_EN also transforms 'a'..'z' with case preserved.
module cipher_stream_sequencer #(
    parameter int unsigned SEC_LEN_MAX = 16,
    parameter int unsigned MSG_LEN_W   = 16,
    localparam int unsigned AW         = $clog2(SEC_LEN_MAX),
    localparam int unsigned KLW        = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_we,
    input  logic [AW-1:0]        key_addr,
    input  logic [7:0]           key_data,
    input  logic [KLW-1:0]       key_len,
    input  logic [MSG_LEN_W-1:0] msg_len,
    input  logic                 decrypt,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [KLW-1:0] KeyMax = KLW'(SEC_LEN_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [7:0]           r_key [SEC_LEN_MAX];
    logic [AW-1:0]        r_key_idx;
    logic [KLW-1:0]       r_key_len;
    logic [MSG_LEN_W-1:0] r_count;
    logic [MSG_LEN_W-1:0] r_msg_len;
    logic                 r_decrypt;
    logic                 r_out_valid;
    logic [7:0]           r_out_data;
    logic                 r_done;
    logic                 r_err;

    logic                 w_launch;
    logic                 w_done_next;
    logic                 w_err_next;
    logic                 w_in_hs;
    logic                 w_out_hs;
    logic                 w_last_in;
    logic                 w_key_wrap;

    logic [7:0]           w_key_byte;
    logic                 w_key_ok;
    logic                 w_is_letter;
    logic [7:0]           w_base;
    logic [4:0]           w_p;
    logic [4:0]           w_k;
    logic [5:0]           w_sum;
    logic [5:0]           w_mod;
    logic [7:0]           w_out_byte;

    assign in_ready  = (r_state == StRun) && (!r_out_valid || out_ready);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != StIdle);
    assign done      = r_done;
    assign err       = r_err;

    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_last_in  = (r_count == r_msg_len - MSG_LEN_W'(1));
    assign w_key_wrap = ({1'b0, r_key_idx} == r_key_len - KLW'(1));

    // Letter classification and base selection for the byte being accepted.
    always_comb begin
        w_base      = 8'd65;
        w_is_letter = (in_data >= 8'd65) && (in_data <= 8'd90);
`ifdef LOWERCASE_EN
        if ((in_data >= 8'd97) && (in_data <= 8'd122)) begin
            w_base      = 8'd97;
            w_is_letter = 1'b1;
        end
`endif
    end

    // Low 5 bits of a byte difference depend only on the low 5 bits of the operands.
    // A non-letter key byte (e.g. a cleared table entry) acts as a zero shift.
    assign w_key_byte = r_key[r_key_idx];
    assign w_key_ok   = (w_key_byte >= 8'd65) && (w_key_byte <= 8'd90);
    assign w_p        = in_data[4:0] - w_base[4:0];
    assign w_k        = w_key_ok ? (w_key_byte[4:0] - 5'd1) : 5'd0;
    assign w_sum      = r_decrypt ? ({1'b0, w_p} + (6'd26 - {1'b0, w_k}))
                                  : ({1'b0, w_p} + {1'b0, w_k});
    assign w_mod      = (w_sum >= 6'd26) ? (w_sum - 6'd26) : w_sum;
    assign w_out_byte = w_is_letter ? (w_base + {2'b00, w_mod}) : in_data;

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    if ((key_len == '0) || (key_len > KeyMax)) begin
                        w_err_next = 1'b1;
                    end else if (msg_len == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_launch     = 1'b1;
                        w_state_next = StRun;
                    end
                end
            end
            StRun: begin
                if (w_in_hs && w_last_in) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_out_hs) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_key_idx   <= '0;
            r_key_len   <= '0;
            r_count     <= '0;
            r_msg_len   <= '0;
            r_decrypt   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < SEC_LEN_MAX; i++) begin
                r_key[i] <= 8'h00;
            end
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;

            if (key_we && (r_state == StIdle) && (32'(key_addr) < SEC_LEN_MAX)) begin
                r_key[key_addr] <= key_data;
            end

            if (w_launch) begin
                r_msg_len <= msg_len;
                r_key_len <= key_len;
                r_decrypt <= decrypt;
                r_key_idx <= '0;
                r_count   <= '0;
            end

            if (w_in_hs) begin
                r_count <= r_count + MSG_LEN_W'(1);
                if (w_is_letter) begin
                    r_key_idx <= w_key_wrap ? '0 : (r_key_idx + AW'(1));
                end
            end

            // Single-entry output stage: load wins, otherwise drain on handshake.
            if (w_in_hs) begin
                r_out_data  <= w_out_byte;
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cipher_stream_sequencer.sv
// Self-checking bench for cipher_stream_sequencer: scoreboard queue filled on input
// handshakes, drained and compared on output handshakes.
module tb_cipher_stream_sequencer;

    localparam int SEC_LEN_MAX = 16;
    localparam int MSG_LEN_W   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_we = 1'b0;
    logic [3:0]  key_addr = '0;
    logic [7:0]  key_data = '0;
    logic [4:0]  key_len = '0;
    logic [15:0] msg_len = '0;
    logic        decrypt = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;
    logic        err;

    cipher_stream_sequencer #(
        .SEC_LEN_MAX(SEC_LEN_MAX),
        .MSG_LEN_W  (MSG_LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_we   (key_we),
        .key_addr (key_addr),
        .key_data (key_data),
        .key_len  (key_len),
        .msg_len  (msg_len),
        .decrypt  (decrypt),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  obs[$];
    logic [7:0]  mkey[SEC_LEN_MAX];
    int          g_beats;
    int          g_dones;
    int          g_lat;
    int          g_stalls;

    function automatic logic [7:0] model(input logic [7:0] c, input logic [7:0] kc,
                                         input bit dec, output bit adv);
        int p, k, base;
        adv   = 1'b0;
        model = c;
        base  = -1;
        if (c >= 8'd65 && c <= 8'd90) base = 65;
`ifdef LOWERCASE_EN
        else if (c >= 8'd97 && c <= 8'd122) base = 97;
`endif
        if (base >= 0) begin
            p   = int'(c) - base;
            k   = (kc >= 8'd65 && kc <= 8'd90) ? int'(kc) - 65 : 0;
            adv = 1'b1;
            if (dec) model = 8'(((p - k + 26) % 26) + base);
            else     model = 8'(((p + k) % 26) + base);
        end
    endfunction

    task automatic write_key(input string k);
        for (int i = 0; i < k.len() && i < SEC_LEN_MAX; i++) begin
            @(negedge clk);
            key_we   = 1'b1;
            key_addr = 4'(i);
            key_data = k[i];
            mkey[i]  = k[i];
        end
        @(negedge clk);
        key_we = 1'b0;
    endtask

    task automatic run_msg(input string msg, input int klen, input bit dec,
                           input int stall_at, input int stall_len);
        int len = msg.len();
        int i = 0, cyc = 0, kidx = 0, stall_n = 0, acc_cyc = -1, out_cyc = -1;
        bit prev_stall = 1'b0;
        bit adv;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] e;
        g_beats = 0; g_dones = 0; g_lat = -1; g_stalls = 0;
        obs.delete();
        exp_q.delete();
        @(negedge clk);
        key_len = 5'(klen); msg_len = 16'(len); decrypt = dec; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(g_beats == len && g_dones > 0) && cyc < 300) begin
            in_valid  = (i < len);
            in_data   = (i < len) ? msg[i] : 8'h00;
            out_ready = 1'b1;
            if (g_beats >= stall_at && stall_n < stall_len) begin
                out_ready = 1'b0;
                stall_n++;
            end
            #1;
            if (done) g_dones++;
            if (out_valid && !out_ready) begin
                g_stalls++;
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
                if (prev_stall) begin
                    n_cmp++;
                    if (out_data !== prev_data) begin
                        n_bad++;
                        $display("FAIL stall_hold: got %h want %h", out_data, prev_data);
                    end
                end
                prev_stall = 1'b1;
                prev_data  = out_data;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (out_cyc < 0) out_cyc = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_extra: got %h want no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_bad++;
                        $display("FAIL sb_byte: got %h want %h", out_data, e);
                    end
                end
                obs.push_back(out_data);
                g_beats++;
            end
            if (in_valid && in_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                e = model(msg[i], mkey[kidx], dec, adv);
                exp_q.push_back(e);
                if (adv) kidx = (kidx + 1 == klen) ? 0 : kidx + 1;
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: beats %0d want %0d, dones %0d", g_beats, len, g_dones);
        end
        g_lat = out_cyc - acc_cyc;
        repeat (3) begin
            #1;
            if (done) g_dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic check_payload(input string name, input string want);
        n_cmp++;
        if (obs.size() != want.len()) begin
            n_bad++;
            $display("FAIL %s_len: got %0d want %0d", name, obs.size(), want.len());
        end else begin
            for (int j = 0; j < want.len(); j++) begin
                n_cmp++;
                if (obs[j] !== want[j]) begin
                    n_bad++;
                    $display("FAIL %s[%0d]: got %h want %h", name, j, obs[j], want[j]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < SEC_LEN_MAX; i++) mkey[i] = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (in_ready  !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data  !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        n_cmp++; if (busy      !== 1'b0)  begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done      !== 1'b0)  begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (err       !== 1'b0)  begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_encrypt();
        write_key("KEY");
        run_msg("HELLO", 3, 1'b0, 99, 0);
        check_payload("enc", "RIJVS");
        n_cmp++; if (g_beats != 5) begin n_bad++; $display("FAIL enc_beats: got %0d want 5", g_beats); end
        n_cmp++; if (g_dones != 1) begin n_bad++; $display("FAIL enc_done: got %0d want 1", g_dones); end
        n_cmp++; if (g_lat != 1)   begin n_bad++; $display("FAIL enc_latency: got %0d want 1", g_lat); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL enc_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_decrypt();
        run_msg("RIJVS", 3, 1'b1, 99, 0);
        check_payload("dec", "HELLO");
        n_cmp++; if (g_dones != 1) begin n_bad++; $display("FAIL dec_done: got %0d want 1", g_dones); end
    endtask

    task automatic test_nonletter();
        write_key("B");
        run_msg("A B", 1, 1'b0, 99, 0);
        check_payload("space", "B C");
        run_msg("a b", 1, 1'b0, 99, 0);
`ifdef LOWERCASE_EN
        check_payload("lower", "b c");
`else
        check_payload("lower", "a b");
`endif
    endtask

    task automatic test_backpressure();
        write_key("KEY");
        run_msg("HELLO", 3, 1'b0, 2, 4);
        check_payload("bp", "RIJVS");
        n_cmp++; if (g_beats != 5)  begin n_bad++; $display("FAIL bp_beats: got %0d want 5", g_beats); end
        n_cmp++; if (g_stalls < 3)  begin n_bad++; $display("FAIL bp_stalls: got %0d want >=3", g_stalls); end
        n_cmp++; if (g_dones != 1)  begin n_bad++; $display("FAIL bp_done: got %0d want 1", g_dones); end
    endtask

    task automatic test_err_and_empty();
        @(negedge clk);
        key_len = 5'd0; msg_len = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (err  !== 1'b1) begin n_bad++; $display("FAIL err_zero: got %b want 1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL err_busy: got %b want 0", busy); end
        @(negedge clk);
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pulse: got %b want 0", err); end
        @(negedge clk);
        key_len = 5'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_big: got %b want 1", err); end
        @(negedge clk);
        key_len = 5'd3; msg_len = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL empty_done: got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy: got %b want 0", busy); end
        @(negedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL empty_pulse: got %b want 0", done); end
    endtask

    task automatic test_midreset();
        int acc = 0;
        int cyc = 0;
        string m = "HELLO";
        write_key("KEY");
        @(negedge clk);
        key_len = 5'd3; msg_len = 16'd5; decrypt = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        while (acc < 2 && cyc < 20) begin
            in_valid = 1'b1;
            in_data  = m[acc];
            #1;
            if (in_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL mid_accept: got %0d want 2", acc); end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < SEC_LEN_MAX; i++) mkey[i] = 8'h00;
        #1;
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data  !== 8'h00) begin n_bad++; $display("FAIL mid_out_data: got %h want 00", out_data); end
        n_cmp++; if (in_ready  !== 1'b0)  begin n_bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (busy      !== 1'b0)  begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        write_key("KEY");
        run_msg("HELLO", 3, 1'b0, 99, 0);
        check_payload("post_rst", "RIJVS");
        n_cmp++; if (g_dones != 1) begin n_bad++; $display("FAIL post_rst_done: got %0d want 1", g_dones); end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_nonletter();
        test_backpressure();
        test_err_and_empty();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
